// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions: word width, the 64 round constants K[0:63],
// the working-variable struct and the Sigma0/Sigma1/Ch/Maj round functions.
// No ports (package).
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Working variables in the order they are packed on the 256-bit buses
    // (a occupies the most significant word).
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } state_t;

    // Leftmost entry is K[0].
    localparam logic [0:63][WORD_W-1:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// sha256_round_comb
// Purely combinational SHA-256 compression round using K[ROUND_IDX].
// Ports:
//   state_in  [255:0] : {a,b,c,d,e,f,g,h}, a at [255:224]
//   w_t       [31:0]  : message schedule word for this round
//   state_out [255:0] : working variables after the round
// All additions wrap modulo 2^32 (word-width arithmetic).
module sha256_round_comb
    import sha256_pkg::*;
#(
    parameter int ROUND_IDX = 27
) (
    input  logic [8*WORD_W-1:0] state_in,
    input  logic [WORD_W-1:0]   w_t,
    output logic [8*WORD_W-1:0] state_out
);

    localparam word_t K_T = K_TABLE[ROUND_IDX];

    state_t s;
    state_t n;
    word_t  t1;
    word_t  t2;

    assign s  = state_in;
    assign t1 = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + K_T + w_t;
    assign t2 = big_sigma0(s.a) + maj(s.a, s.b, s.c);

    always_comb begin
        n   = '0;
        n.a = t1 + t2;
        n.b = s.a;
        n.c = s.b;
        n.d = s.c;
        n.e = s.d + t1;
        n.f = s.e;
        n.g = s.f;
        n.h = s.g;
    end

    assign state_out = n;

endmodule

// File: rtl/sha256_round_stage_pipeline.sv
// sha256_round_stage_pipeline
// One registered SHA-256 round stage with valid/ready handshaking.
// Optional feature macro: SHA256_ROUND_SKID_EN
//   defined   : 2-entry skid buffer (main + skid), in_ready registered = !skid_full
//   undefined : single output register, in_ready = !out_valid || out_ready
// Ports:
//   CLK, RST (async, active-low)
//   in_valid / in_ready   : input handshake
//   state_in     [255:0]  : {a..h}, a at [255:224]
//   w_window_in  [383:0]  : 12-word schedule window, W_t at [31:0]
//   out_valid / out_ready : output handshake
//   state_out    [255:0]  : working variables after round ROUND_IDX
//   w_window_out [351:0]  : w_window_in[351:0], oldest word dropped
//
// Handshake: a word moves on a rising edge where valid && ready are both 1.
// out_valid is a pure register output and never looks at out_ready; while
// out_valid=1 and out_ready=0 the output data is held unchanged.
module sha256_round_stage_pipeline
    import sha256_pkg::*;
#(
    parameter int ROUND_IDX = 27
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORD_W-1:0]  state_in,
    input  logic [12*WORD_W-1:0] w_window_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORD_W-1:0]  state_out,
    output logic [11*WORD_W-1:0] w_window_out
);

    logic [8*WORD_W-1:0]  round_state;
    logic [11*WORD_W-1:0] next_window;
    logic                 in_fire;
    logic                 out_fire;
    logic                 unused_oldest_word;

    sha256_round_comb #(
        .ROUND_IDX (ROUND_IDX)
    ) u_round (
        .state_in  (state_in),
        .w_t       (w_window_in[WORD_W-1:0]),
        .state_out (round_state)
    );

    // The oldest schedule word leaves the window here.
    assign next_window        = w_window_in[11*WORD_W-1:0];
    assign unused_oldest_word = ^w_window_in[12*WORD_W-1:11*WORD_W];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef SHA256_ROUND_SKID_EN
    logic                 skid_valid;
    logic [8*WORD_W-1:0]  skid_state;
    logic [11*WORD_W-1:0] skid_window;

    // in_ready mirrors !skid_valid one cycle ahead, so it is always the
    // registered complement of the skid occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid    <= 1'b0;
            state_out    <= '0;
            w_window_out <= '0;
            skid_valid   <= 1'b0;
            skid_state   <= '0;
            skid_window  <= '0;
            in_ready     <= 1'b0;
        end else if (skid_valid) begin
            // Input is blocked; main can only drain and be refilled from skid.
            in_ready <= out_fire;
            if (out_fire) begin
                state_out    <= skid_state;
                w_window_out <= skid_window;
                skid_valid   <= 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid || out_ready) begin
                state_out    <= round_state;
                w_window_out <= next_window;
                out_valid    <= 1'b1;
                in_ready     <= 1'b1;
            end else begin
                // Main is stalled: park the new result behind it.
                skid_state  <= round_state;
                skid_window <= next_window;
                skid_valid  <= 1'b1;
                in_ready    <= 1'b0;
            end
        end else begin
            in_ready <= 1'b1;
            if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    // Gated with RST so nothing is offered as accepted while in reset.
    assign in_ready = RST && (!out_valid || out_ready);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid    <= 1'b0;
            state_out    <= '0;
            w_window_out <= '0;
        end else if (in_fire) begin
            state_out    <= round_state;
            w_window_out <= next_window;
            out_valid    <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_round_stage_pipeline.sv
module tb_sha256_round_stage_pipeline;

    localparam int SW = 256;
    localparam int WW = 384;
    localparam int OW = 352;
    localparam int EW = SW + OW;
`ifdef SHA256_ROUND_SKID_EN
    localparam int HELD = 2;
`else
    localparam int HELD = 1;
`endif
    localparam logic [31:0] K0  = 32'h428a2f98;
    localparam logic [31:0] K27 = 32'hbf597fc7;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] state_in = '0;
    logic [WW-1:0] w_window_in = '0;

    logic          in_ready0, in_ready27, out_valid0, out_valid27;
    logic [SW-1:0] state_out0, state_out27;
    logic [OW-1:0] w_out0, w_out27;

    sha256_round_stage_pipeline #(.ROUND_IDX(0)) dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0),
        .state_in(state_in), .w_window_in(w_window_in),
        .out_valid(out_valid0), .out_ready(out_ready),
        .state_out(state_out0), .w_window_out(w_out0)
    );

    sha256_round_stage_pipeline dut27 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready27),
        .state_in(state_in), .w_window_in(w_window_in),
        .out_valid(out_valid27), .out_ready(out_ready),
        .state_out(state_out27), .w_window_out(w_out27)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q27[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [31:0] add32(input logic [63:0] s);
        return 32'(s % 64'h1_0000_0000);
    endfunction

    function automatic logic [SW-1:0] ref_round(input logic [SW-1:0] st, input logic [31:0] w,
                                                 input logic [31:0] k);
        logic [31:0] v[8];
        logic [31:0] s1, chv, t1, s0, mj, t2;
        for (int i = 0; i < 8; i++) v[i] = st[SW-1-32*i -: 32];
        s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
        chv = (v[4] & v[5]) | (~v[4] & v[6]);
        t1  = add32(64'(v[7]) + 64'(s1) + 64'(chv) + 64'(k) + 64'(w));
        s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
        mj  = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
        t2  = add32(64'(s0) + 64'(mj));
        return {add32(64'(t1) + 64'(t2)), v[0], v[1], v[2], add32(64'(v[3]) + 64'(t1)), v[4], v[5], v[6]};
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- driver ----------------
    // One clock: drive, settle, score any output transfer, record any
    // input transfer, then advance to 1 time unit after the edge.
    task automatic cycle(input logic iv, input logic [SW-1:0] st, input logic [WW-1:0] win,
                         input logic ordy, output logic acc);
        logic [EW-1:0] e;
        in_valid    = iv;
        state_in    = st;
        w_window_in = win;
        out_ready   = ordy;
        #1;
        chk("in_ready_pair", EW'(in_ready27), EW'(in_ready0));
        chk("out_valid_pair", EW'(out_valid27), EW'(out_valid0));
        acc = iv && in_ready0;
        if (out_valid0 && ordy) begin
            chk("output_expected", EW'(exp_q0.size() != 0), EW'(1));
            if (exp_q0.size() != 0) begin
                e = exp_q0.pop_front();
                chk("data_r0", {state_out0, w_out0}, e);
                e = exp_q27.pop_front();
                chk("data_r27", {state_out27, w_out27}, e);
            end
        end
        if (acc) begin
            exp_q0.push_back({ref_round(st, win[31:0], K0), win[OW-1:0]});
            exp_q27.push_back({ref_round(st, win[31:0], K27), win[OW-1:0]});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        while (!in_ready0 && n < 10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(tag, EW'(in_ready0), EW'(1));
    endtask

    task automatic drain(input string tag);
        logic acc;
        int n;
        n = 0;
        while (exp_q0.size() != 0 && n < 20) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            n++;
        end
        chk({tag, "_empty"}, EW'(exp_q0.size()), EW'(0));
        chk({tag, "_idle"}, EW'(out_valid0), EW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic          acc;
        int            nacc;
        logic [SW-1:0] iv_state;
        logic [SW-1:0] abc_exp;
        logic [WW-1:0] win;
        logic [OW-1:0] win_exp;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", EW'(out_valid0), EW'(0));
        chk("rst_in_ready", EW'(in_ready0), EW'(0));
        chk("rst_state_out", EW'(state_out0), EW'(0));
        chk("rst_window_out", EW'(w_out0), EW'(0));
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        #1;
        wait_ready("post_reset_ready");

        // FIPS "abc" first round
        iv_state = {32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
        abc_exp  = {32'h5D6AEBCD, 32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372,
                    32'hFA2A4622, 32'h510E527F, 32'h9B05688C, 32'h1F83D9AB};
        win = '0;
        win[31:0] = 32'h61626380;
        cycle(1'b1, iv_state, win, 1'b0, acc);
        chk("abc_accept", EW'(acc), EW'(1));
        chk("abc_valid_1cyc", EW'(out_valid0), EW'(1));
        chk("abc_state", EW'(state_out0), EW'(abc_exp));
        drain("abc_drain");

        // Window shift
        for (int i = 0; i < 12; i++) win[WW-1-32*i -: 32] = 32'(i);
        for (int i = 1; i < 12; i++) win_exp[OW-1-32*(i-1) -: 32] = 32'(i);
        cycle(1'b1, rand_state(), win, 1'b0, acc);
        chk("win_shift", EW'(w_out0), EW'(win_exp));
        drain("win_drain");

        // Overflow: everything all-ones
        cycle(1'b1, {SW{1'b1}}, {WW{1'b1}}, 1'b1, acc);
        chk("ovf_accept", EW'(acc), EW'(1));
        drain("ovf_drain");

        // Streaming: 16 back-to-back, no bubbles
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, rand_state(), rand_win(), 1'b1, acc);
            chk("stream_accept", EW'(acc), EW'(1));
            chk("stream_no_bubble", EW'(out_valid0), EW'(1));
        end
        drain("stream_drain");

        // Backpressure: 5 stalled cycles with input offered
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, rand_state(), rand_win(), 1'b0, acc);
            if (acc) nacc++;
            chk("bp_valid_held", EW'(out_valid0), EW'(1));
            chk("bp_data_stable", {state_out0, w_out0}, exp_q0[0]);
        end
        chk("bp_items_held", EW'(nacc), EW'(HELD));
        chk("bp_in_ready_low", EW'(in_ready0), EW'(0));
        drain("bp_drain");

        // Reset in the middle of a stall
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_state(), rand_win(), 1'b0, acc);
        chk("mid_rst_held", EW'(exp_q0.size()), EW'(HELD));
        in_valid = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_out_valid", EW'(out_valid0), EW'(0));
        chk("mid_rst_state", EW'(state_out0), EW'(0));
        chk("mid_rst_window", EW'(w_out0), EW'(0));
        chk("mid_rst_in_ready", EW'(in_ready0), EW'(0));
        exp_q0.delete();
        exp_q27.delete();
        @(negedge CLK);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        #1;
        wait_ready("mid_rst_ready");
        cycle(1'b1, rand_state(), rand_win(), 1'b1, acc);
        chk("mid_rst_new_accept", EW'(acc), EW'(1));
        drain("mid_rst_drain");
        cycle(1'b0, '0, '0, 1'b1, acc);
        chk("mid_rst_no_extra", EW'(out_valid0), EW'(0));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_state(), rand_win(),
                  1'($urandom_range(0, 3) != 0), acc);
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
